// File: rtl/fpu_mul_collect_if.sv
// Beat-in / wave-out bundle between the FP32 multiplier lanes and the VGPR writeback side.
// slave is the collector's view; master is the view of whoever drives beats and consumes waves.
interface fpu_mul_collect_if #(
  parameter int BIT_WIDTH = 32,
  parameter int LANES     = 32,
  parameter int LANE_W    = $clog2(LANES)
);
  logic                       i_valid;
  logic                       o_ready;
  logic [BIT_WIDTH-1:0]       i_result;
  logic                       i_inexact;
  logic                       i_exec;
  logic                       o_valid;
  logic                       i_ready;
  logic [LANES*BIT_WIDTH-1:0] o_wave;
  logic [LANES-1:0]           o_exec;
  logic                       o_inexact;
  logic [LANE_W-1:0]          o_lane;

  modport slave (
    input  i_valid, i_result, i_inexact, i_exec, i_ready,
    output o_ready, o_valid, o_wave, o_exec, o_inexact, o_lane
  );

  modport master (
    output i_valid, i_result, i_inexact, i_exec, i_ready,
    input  o_ready, o_valid, o_wave, o_exec, o_inexact, o_lane
  );
endinterface

// File: rtl/fpu_mul_collect.sv
// Collects per-lane multiplier beats into ping-pong wave buffers; wave visible 1 cycle after its last beat.
// Backpressure: o_ready drops only when both buffers hold unpopped waves, and is driven from registers only.
module fpu_mul_collect #(
  parameter int BIT_WIDTH = 32,
  parameter int LANES     = 32,
  parameter int LANE_W    = $clog2(LANES)
) (
  input logic            i_clk,
  input logic            i_rst,
  fpu_mul_collect_if.slave bus
);

  logic              wrBuf;
  logic              rdBuf;
  logic [LANE_W-1:0] wrLane;
  logic [1:0]        full;
  logic [1:0]        fullNext;
  logic [1:0]        inexAcc;
  logic              rstQ;

  logic [BIT_WIDTH-1:0] waveMem [2][LANES];
  logic [LANES-1:0]     execMem [2];

  logic accept;
  logic pop;
  logic lastLane;

  assign accept   = bus.i_valid && bus.o_ready;
  assign pop      = bus.o_valid && bus.i_ready;
  assign lastLane = (wrLane == LANE_W'(LANES - 1));

  // A pop and a completion can never target the same buffer: one needs it full, the other empty.
  always_comb begin
    fullNext = full;
    if (pop)
      fullNext[rdBuf] = 1'b0;
    if (accept && lastLane)
      fullNext[wrBuf] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wrBuf   <= 1'b0;
      rdBuf   <= 1'b0;
      wrLane  <= '0;
      full    <= 2'b00;
      inexAcc <= 2'b00;
      rstQ    <= 1'b1;
    end else begin
      rstQ <= 1'b0;
      full <= fullNext;
      if (accept) begin
        wrLane          <= lastLane ? '0 : wrLane + 1'b1;
        inexAcc[wrBuf]  <= ((wrLane == '0) ? 1'b0 : inexAcc[wrBuf]) | (bus.i_exec & bus.i_inexact);
        if (lastLane)
          wrBuf <= ~wrBuf;
      end
      if (pop)
        rdBuf <= ~rdBuf;
    end
  end

  // Storage is left unreset; every lane is rewritten each wave and outputs are gated by o_valid.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      waveMem[wrBuf][wrLane] <= bus.i_exec ? bus.i_result : '0;
      execMem[wrBuf][wrLane] <= bus.i_exec;
    end
  end

  assign bus.o_ready   = !rstQ && !full[wrBuf];
  assign bus.o_valid   = full[rdBuf];
  assign bus.o_exec    = bus.o_valid ? execMem[rdBuf] : '0;
  assign bus.o_inexact = bus.o_valid & inexAcc[rdBuf];
  assign bus.o_lane    = wrLane;

  always_comb begin
    bus.o_wave = '0;
    for (int k = 0; k < LANES; k++)
      bus.o_wave[k*BIT_WIDTH +: BIT_WIDTH] = bus.o_valid ? waveMem[rdBuf][k] : '0;
  end

endmodule

// File: tb/tb_fpu_mul_collect.sv
// Bench for fpu_mul_collect: wave-level reference model checked every cycle, plus vector table and corner sequences.
module tb_fpu_mul_collect;
  localparam int BW = 32;
  localparam int LN = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fpu_mul_collect_if #(.BIT_WIDTH(BW), .LANES(LN)) bus ();
  fpu_mul_collect #(.BIT_WIDTH(BW), .LANES(LN)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  typedef struct {
    logic [LN*BW-1:0] wave;
    logic [LN-1:0]    exec;
    logic             inex;
  } wave_t;

  typedef struct {
    logic [31:0] execM;
    logic [31:0] inexM;
    logic [31:0] base;
    logic [31:0] expExec;
    logic        expInex;
  } vec_t;

  // Reference model: completed waves awaiting pop, plus raw beats of the wave being assembled.
  wave_t         q[$];
  logic [BW-1:0] pr [LN];
  logic [LN-1:0] pe;
  logic [LN-1:0] pi;
  int            lane = 0;
  bit            inRst = 1'b1;
  bit            started = 1'b0;
  bit            lastAcc = 1'b0;
  int            nTests = 0;
  int            nFail = 0;
  int            dutAcc = 0;
  int            popped = 0;

  logic [BW-1:0] curR;
  bit            curIx;
  bit            curEx;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkWave(input string name, input logic [LN*BW-1:0] exp);
    bit shown = 1'b0;
    nTests++;
    if (bus.o_wave !== exp) begin
      nFail++;
      for (int k = 0; k < LN; k++) begin
        if (!shown && bus.o_wave[k*BW +: BW] !== exp[k*BW +: BW]) begin
          $display("FAIL %s lane %0d: got %h expected %h at %0t", name, k,
                   bus.o_wave[k*BW +: BW], exp[k*BW +: BW], $time);
          shown = 1'b1;
        end
      end
    end
  endtask

  task automatic checkAll();
    bit v;
    v = (q.size() > 0);
    chk("o_ready", bus.o_ready, (!inRst && q.size() < 2));
    chk("o_valid", bus.o_valid, v);
    chk("o_lane", bus.o_lane, lane);
    if (v) begin
      chk("o_exec", bus.o_exec, q[0].exec);
      chk("o_inexact", bus.o_inexact, q[0].inex);
      chkWave("o_wave", q[0].wave);
    end else begin
      chk("o_exec_idle", bus.o_exec, 0);
      chk("o_inexact_idle", bus.o_inexact, 0);
      chkWave("o_wave_idle", '0);
    end
  endtask

  task automatic pushWave();
    wave_t w;
    for (int k = 0; k < LN; k++)
      w.wave[k*BW +: BW] = pe[k] ? pr[k] : '0;
    w.exec = pe;
    w.inex = |(pe & pi);
    q.push_back(w);
  endtask

  task automatic tick(input bit v, input logic [BW-1:0] r, input bit ix, input bit ex,
                      input bit rdy, input bit rs);
    bit acc;
    bit pop;
    bit expRdy;
    bus.i_valid   = v;
    bus.i_result  = r;
    bus.i_inexact = ix;
    bus.i_exec    = ex;
    bus.i_ready   = rdy;
    rst           = rs;
    expRdy = !inRst && (q.size() < 2);
    #2;
    if (started)
      chk("ready_comb", bus.o_ready, expRdy);
    if (started && !rs && v && bus.o_ready === 1'b1)
      dutAcc++;
    acc = !rs && v && expRdy;
    pop = !rs && (q.size() > 0) && rdy;
    @(posedge clk);
    #1;
    if (rs) begin
      q.delete();
      lane    = 0;
      inRst   = 1'b1;
      started = 1'b1;
    end else begin
      inRst = 1'b0;
      if (pop) begin
        void'(q.pop_front());
        popped++;
      end
      if (acc) begin
        pr[lane] = r;
        pe[lane] = ex;
        pi[lane] = ix;
        lane++;
        if (lane == LN) begin
          pushWave();
          lane = 0;
        end
      end
    end
    lastAcc = acc;
    if (started)
      checkAll();
  endtask

  task automatic idle(input bit rdy);
    tick(1'b0, '0, 1'b0, 1'b0, rdy, 1'b0);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 100) begin
      idle(1'b1);
      n++;
    end
    chk("drain_timeout", q.size(), 0);
  endtask

  task automatic newBeat();
    curR  = $urandom;
    curIx = ($urandom_range(0, 3) == 0);
    curEx = ($urandom_range(0, 3) != 0);
  endtask

  vec_t             vt [5];
  logic [LN*BW-1:0] expW;
  wave_t            w2;
  int               cyc;

  initial begin
    vt[0] = '{execM: 32'hFFFF_FFFF, inexM: 32'h0000_0000, base: 32'h3F80_0000, expExec: 32'hFFFF_FFFF, expInex: 1'b0};
    vt[1] = '{execM: 32'h0000_FFF0, inexM: 32'h0010_0004, base: 32'h4000_0000, expExec: 32'h0000_FFF0, expInex: 1'b0};
    vt[2] = '{execM: 32'h0000_FFF0, inexM: 32'h0000_0020, base: 32'h4100_0000, expExec: 32'h0000_FFF0, expInex: 1'b1};
    vt[3] = '{execM: 32'h0000_0000, inexM: 32'hFFFF_FFFF, base: 32'h4200_0000, expExec: 32'h0000_0000, expInex: 1'b0};
    vt[4] = '{execM: 32'hAAAA_AAAA, inexM: 32'h8000_0000, base: 32'hBF80_0000, expExec: 32'hAAAA_AAAA, expInex: 1'b1};

    tick(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_ready", bus.o_ready, 0);
    chk("rst_valid", bus.o_valid, 0);
    chk("rst_lane", bus.o_lane, 0);
    idle(1'b0);
    chk("rst_release_ready", bus.o_ready, 1);

    // Vector table: one wave per entry, popped as soon as it appears.
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < LN; k++) begin
        tick(1'b1, vt[i].base + 32'(k), vt[i].inexM[k], vt[i].execM[k], 1'b1, 1'b0);
        if (k == LN - 2)
          chk("tbl_early_valid", bus.o_valid, 0);
      end
      for (int k = 0; k < LN; k++)
        expW[k*BW +: BW] = vt[i].execM[k] ? vt[i].base + 32'(k) : 32'h0;
      chk("tbl_valid", bus.o_valid, 1);
      chk("tbl_exec", bus.o_exec, vt[i].expExec);
      chk("tbl_inexact", bus.o_inexact, vt[i].expInex);
      chkWave("tbl_wave", expW);
    end
    drain();

    // Permanent backpressure: two buffers fill, then upstream stalls.
    dutAcc = 0;
    newBeat();
    for (int n = 0; n < 70; n++) begin
      tick(1'b1, curR, curIx, curEx, 1'b0, 1'b0);
      if (lastAcc)
        newBeat();
    end
    chk("bp_accepted", dutAcc, 64);
    chk("bp_ready_low", bus.o_ready, 0);
    w2 = q[1];
    idle(1'b1);
    chk("bp_pop_ready", bus.o_ready, 1);
    chk("bp_second_valid", bus.o_valid, 1);
    chkWave("bp_second_wave", w2.wave);
    idle(1'b0);
    chkWave("bp_second_hold", w2.wave);
    drain();

    // Pop of the older wave on the same edge as the last beat of the newer one.
    for (int k = 0; k < LN; k++)
      tick(1'b1, 32'h1000_0000 + 32'(k), 1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < LN; k++)
      tick(1'b1, 32'h2000_0000 + 32'(k), 1'b0, k inside {2, 4, 5, 9, 12, 16, 17, 18, 19, 24, 25, 26, 27},
           (k == LN - 1), 1'b0);
    chk("pc_valid", bus.o_valid, 1);
    chk("pc_exec", bus.o_exec, 32'h0F0F_1234 & 32'h0000_0000 | 32'h0F0F_1234);
    chk("pc_lane", bus.o_lane, 0);
    drain();

    // Reset with a full wave pending and a partial wave in flight.
    for (int k = 0; k < LN + 17; k++)
      tick(1'b1, 32'h7F00_0000 + 32'(k), 1'b1, 1'b1, 1'b0, 1'b0);
    tick(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("mr_valid", bus.o_valid, 0);
    chk("mr_lane", bus.o_lane, 0);
    idle(1'b0);
    for (int k = 0; k < LN; k++)
      tick(1'b1, 32'hC000_0000 + 32'(k), 1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < LN; k++)
      expW[k*BW +: BW] = 32'hC000_0000 + 32'(k);
    chk("mr_new_valid", bus.o_valid, 1);
    chk("mr_new_inexact", bus.o_inexact, 0);
    chkWave("mr_new_wave", expW);
    drain();

    // Random traffic against the model.
    popped = 0;
    cyc = 0;
    newBeat();
    while (popped < 200 && cyc < 40000) begin
      tick($urandom_range(0, 1) == 1, curR, curIx, curEx, $urandom_range(0, 1) == 1, 1'b0);
      if (lastAcc)
        newBeat();
      cyc++;
    end
    chk("rand_waves_done", (popped >= 200), 1);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
